// File: rtl/motion_pkg.sv
// Shared constants, block min/max bundle and combine helpers
// for the 4x4 block min/max reducer.
package motion_pkg;

  localparam int PIX_W    = 4;
  localparam int IMG_W    = 320;
  localparam int IMG_H    = 240;
  localparam int BLK_SZ   = 4;
  localparam int BLK_COLS = IMG_W / BLK_SZ;
  localparam int BLK_ROWS = IMG_H / BLK_SZ;
  localparam int NUM_BLKS = BLK_COLS * BLK_ROWS;
  localparam int ADDR_W   = 13;

  typedef struct packed {
    logic [PIX_W-1:0] max;
    logic [PIX_W-1:0] min;
  } minmax_t;

  function automatic logic [PIX_W-1:0] pix_max(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic [PIX_W-1:0] pix_min(
    input logic [PIX_W-1:0] a,
    input logic [PIX_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic minmax_t mm_comb(
    input minmax_t a,
    input minmax_t b
  );
    minmax_t r;
    r.max = pix_max(a.max, b.max);
    r.min = pix_min(a.min, b.min);
    return r;
  endfunction

  function automatic minmax_t mm_pix(
    input logic [PIX_W-1:0] p
  );
    minmax_t r;
    r.max = p;
    r.min = p;
    return r;
  endfunction

endpackage

// File: rtl/block_minmax_4x4_row_buf.sv
// Per-block-column partial min/max store; combinational read,
// synchronous write, no reset on the array.
module blk_row_buf
  import motion_pkg::*;
#(
  parameter int DEPTH = BLK_COLS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [2*PIX_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [2*PIX_W-1:0] rdata
);

  logic [2*PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/block_minmax_4x4.sv
// Raster pixel stream -> per-4x4-block min/max writes.
// Optional din_range output under `BLOCK_RANGE_OUT_EN.
module block_minmax_4x4
  import motion_pkg::*;
#(
  parameter int IMG_W = motion_pkg::IMG_W,
  parameter int IMG_H = motion_pkg::IMG_H
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              wea,
  output logic [ADDR_W-1:0] addr_write,
  output logic [PIX_W-1:0]  din_max,
  output logic [PIX_W-1:0]  din_min,
`ifdef BLOCK_RANGE_OUT_EN
  output logic [PIX_W-1:0]  din_range,
`endif
  output logic              frame_done,
  output logic              frame_err
);

  localparam int COLS = IMG_W / BLK_SZ;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int AW   = $clog2(COLS);

  logic [XW-1:0] x, cx;
  logic [YW-1:0] y, cy;
  logic          done;
  logic          acc;
  logic          row_end;
  logic          last_row;
  logic          rb_we;
  logic          blk_end;
  minmax_t       h;
  minmax_t       h_nxt;
  minmax_t       v_nxt;
  minmax_t       rb_rd;
  logic [ADDR_W-1:0] blk_addr;

  // frame_start takes effect on the same-cycle pixel
  always_comb begin
    cx       = frame_start ? '0 : x;
    cy       = frame_start ? '0 : y;
    acc      = pix_valid & (frame_start | ~done);
    row_end  = (cx == XW'(IMG_W - 1));
    last_row = (cy == YW'(IMG_H - 1));
    h_nxt    = (cx[1:0] == 2'd0) ? mm_pix(pix_data)
             : mm_comb(h, mm_pix(pix_data));
    v_nxt    = (cy[1:0] == 2'd0) ? h_nxt
             : mm_comb(rb_rd, h_nxt);
    rb_we    = acc & (cx[1:0] == 2'd3)
             & (cy[1:0] != 2'd3);
    blk_end  = acc & (cx[1:0] == 2'd3)
             & (cy[1:0] == 2'd3);
    blk_addr = ADDR_W'(cy >> 2) * ADDR_W'(COLS)
             + ADDR_W'(cx >> 2);
  end

  blk_row_buf #(
    .DEPTH (COLS),
    .AW    (AW)
  ) u_row_buf (
    .clk   (clk),
    .we    (rb_we),
    .waddr (AW'(cx >> 2)),
    .wdata (v_nxt),
    .raddr (AW'(cx >> 2)),
    .rdata (rb_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      done <= 1'b0;
      h    <= '0;
    end else if (acc) begin
      h <= h_nxt;
      if (row_end) begin
        x    <= '0;
        y    <= last_row ? '0 : cy + YW'(1);
        done <= last_row;
      end else begin
        x    <= cx + XW'(1);
        y    <= cy;
        done <= 1'b0;
      end
    end else if (frame_start) begin
      x    <= '0;
      y    <= '0;
      done <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else if (frame_start) begin
      frame_err <= 1'b0;
    end else if (pix_valid & done) begin
      frame_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wea        <= 1'b0;
      frame_done <= 1'b0;
      addr_write <= '0;
      din_max    <= '0;
      din_min    <= '0;
    end else begin
      wea        <= blk_end;
      frame_done <= blk_end & row_end & last_row;
      if (blk_end) begin
        addr_write <= blk_addr;
        din_max    <= v_nxt.max;
        din_min    <= v_nxt.min;
      end
    end
  end

`ifdef BLOCK_RANGE_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_range <= '0;
    end else if (blk_end) begin
      din_range <= v_nxt.max - v_nxt.min;
    end
  end
`endif

endmodule
